// File: rtl/fft8_frame_ctrl_if.sv
// Streaming ports of the 8-point FFT frame controller: serial real samples in, complex bins out.
interface fft8_frame_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_re;
    logic [DATA_W-1:0] out_im;
    logic [2:0]        out_idx;
    logic              out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_re, out_im, out_idx, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_idx, out_last
    );
endinterface

// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer around a combinational 8-point FFT core: gathers 8 samples, lets the core
// settle, captures the 16 result words and streams the bins out while the next frame loads.
module fft8_frame_ctrl #(
    parameter int DATA_W = 32,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    fft8_frame_ctrl_if.slave    io,
    output logic [8*DATA_W-1:0] core_a,
    input  logic [8*DATA_W-1:0] core_xr,
    input  logic [8*DATA_W-1:0] core_xi,
    output logic                busy,
    output logic [CNT_W-1:0]    frame_cnt
);
    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_UNLOAD = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_t              state_r, state_s;
    logic                run_r;
    logic [2:0]          wr_idx_r;
    logic [2:0]          rd_idx_r, rd_idx_s;
    logic                frame_full_r, frame_full_s;
    logic                res_valid_r, res_valid_s;
    logic [3:0]          settle_r, settle_s;
    logic [CNT_W-1:0]    frame_cnt_r;
    logic [8*DATA_W-1:0] core_a_r;
    logic [DATA_W-1:0]   res_re_r [0:7];
    logic [DATA_W-1:0]   res_im_r [0:7];
    logic                capture_s, cnt_inc_s;
    logic                in_ready_s, in_acc_s, out_acc_s;

    // run_r keeps in_ready low through reset and releases it one edge later
    assign in_ready_s = run_r && !frame_full_r && (state_r != ST_SETTLE);
    assign in_acc_s   = io.in_valid && in_ready_s && !clear;
    assign out_acc_s  = res_valid_r && io.out_ready && !clear;

    // Next-state and control decode
    always_comb begin
        state_s      = state_r;
        settle_s     = settle_r;
        frame_full_s = frame_full_r;
        res_valid_s  = res_valid_r;
        rd_idx_s     = rd_idx_r;
        capture_s    = 1'b0;
        cnt_inc_s    = 1'b0;
        if (in_acc_s && (wr_idx_r == 3'd7)) begin
            frame_full_s = 1'b1;
        end else begin
            frame_full_s = frame_full_r;
        end
        case (state_r)
            ST_LOAD: begin
                if (frame_full_r && !res_valid_r) begin
                    state_s  = ST_SETTLE;
                    settle_s = SETTLE_M1;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_SETTLE: begin
                if (settle_r == 4'd0) begin
                    capture_s    = 1'b1;
                    res_valid_s  = 1'b1;
                    frame_full_s = 1'b0;
                    rd_idx_s     = 3'd0;
                    state_s      = ST_UNLOAD;
                end else begin
                    settle_s = settle_r - 4'd1;
                end
            end
            ST_UNLOAD: begin
                if (out_acc_s) begin
                    rd_idx_s = rd_idx_r + 3'd1;
                    if (rd_idx_r == 3'd7) begin
                        res_valid_s = 1'b0;
                        cnt_inc_s   = 1'b1;
                        // a frame completed during unload goes straight to settling
                        if (frame_full_r) begin
                            state_s  = ST_SETTLE;
                            settle_s = SETTLE_M1;
                        end else begin
                            state_s = ST_LOAD;
                        end
                    end else begin
                        state_s = ST_UNLOAD;
                    end
                end else begin
                    state_s = ST_UNLOAD;
                end
            end
            default: begin
                state_s = ST_LOAD;
            end
        endcase
        if (clear) begin
            state_s      = ST_LOAD;
            settle_s     = 4'd0;
            frame_full_s = 1'b0;
            res_valid_s  = 1'b0;
            rd_idx_s     = 3'd0;
            capture_s    = 1'b0;
            cnt_inc_s    = 1'b0;
        end else begin
            cnt_inc_s = cnt_inc_s;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_LOAD;
            run_r        <= 1'b0;
            settle_r     <= 4'd0;
            frame_full_r <= 1'b0;
            res_valid_r  <= 1'b0;
            rd_idx_r     <= 3'd0;
            frame_cnt_r  <= '0;
        end else begin
            state_r      <= state_s;
            run_r        <= 1'b1;
            settle_r     <= settle_s;
            frame_full_r <= frame_full_s;
            res_valid_r  <= res_valid_s;
            rd_idx_r     <= rd_idx_s;
            if (cnt_inc_s) begin
                frame_cnt_r <= frame_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    // Input slot writes; clear rewinds the slot pointer but keeps the held samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_r <= 3'd0;
            core_a_r <= '0;
        end else if (clear) begin
            wr_idx_r <= 3'd0;
        end else if (in_acc_s) begin
            core_a_r[int'(wr_idx_r)*DATA_W +: DATA_W] <= io.in_data;
            wr_idx_r <= wr_idx_r + 3'd1;
        end else begin
            wr_idx_r <= wr_idx_r;
        end
    end

    // Result capture from the settled core outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                res_re_r[k] <= '0;
                res_im_r[k] <= '0;
            end
        end else if (capture_s) begin
            for (int k = 0; k < 8; k++) begin
                res_re_r[k] <= core_xr[k*DATA_W +: DATA_W];
                res_im_r[k] <= core_xi[k*DATA_W +: DATA_W];
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                res_re_r[k] <= res_re_r[k];
                res_im_r[k] <= res_im_r[k];
            end
        end
    end

    assign io.in_ready  = in_ready_s;
    assign io.out_valid = res_valid_r;
    assign io.out_re    = res_re_r[rd_idx_r];
    assign io.out_im    = res_im_r[rd_idx_r];
    assign io.out_idx   = rd_idx_r;
    assign io.out_last  = (rd_idx_r == 3'd7);
    assign core_a       = core_a_r;
    assign frame_cnt    = frame_cnt_r;
    assign busy         = (state_r == ST_SETTLE) || res_valid_r || frame_full_r || (wr_idx_r != 3'd0);
endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Directed bench for fft8_frame_ctrl with a stub core (Xr_k = A_k + k, Xi_k = A_k - k).
module tb_fft8_frame_ctrl;
    logic         clk;
    logic         rst_n;
    logic         clear;
    logic [255:0] core_a;
    logic [255:0] core_xr;
    logic [255:0] core_xi;
    logic         busy;
    logic [1:0]   frame_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int fa [8];
    int fb [8];
    int er [8];
    int ei [8];

    fft8_frame_ctrl_if #(.DATA_W(32)) io ();

    fft8_frame_ctrl #(.DATA_W(32), .SETTLE(2), .CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .io        (io),
        .core_a    (core_a),
        .core_xr   (core_xr),
        .core_xi   (core_xi),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        core_xr = '0;
        core_xi = '0;
        for (int k = 0; k < 8; k++) begin
            core_xr[k*32 +: 32] = core_a[k*32 +: 32] + 32'(k);
            core_xi[k*32 +: 32] = core_a[k*32 +: 32] - 32'(k);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int v);
        int n;
        n = 0;
        io.in_valid = 1'b1;
        io.in_data  = 32'(v);
        while (!io.in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("feed_ready", {31'd0, io.in_ready}, 32'd1);
        tick();
        io.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!io.out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("wait_valid", {31'd0, io.out_valid}, 32'd1);
    endtask

    task automatic set_exp_from_fa();
        for (int k = 0; k < 8; k++) begin
            er[k] = fa[k] + k;
            ei[k] = fa[k] - k;
        end
    endtask

    task automatic check_bin(input int k);
        chk("bin_valid", {31'd0, io.out_valid}, 32'd1);
        chk("bin_idx",   {29'd0, io.out_idx},   32'(k));
        chk("bin_re",    io.out_re,             32'(er[k]));
        chk("bin_im",    io.out_im,             32'(ei[k]));
        chk("bin_last",  {31'd0, io.out_last},  (k == 7) ? 32'd1 : 32'd0);
    endtask

    task automatic unload(input int stall_k);
        for (int k = 0; k < 8; k++) begin
            if (k == stall_k) begin
                io.out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk("bp_valid", {31'd0, io.out_valid}, 32'd1);
                    chk("bp_idx",   {29'd0, io.out_idx},   32'(k));
                    chk("bp_re",    io.out_re,             32'(er[k]));
                    chk("bp_im",    io.out_im,             32'(ei[k]));
                end
                io.out_ready = 1'b1;
            end
            check_bin(k);
            tick();
        end
        chk("unload_done", {31'd0, io.out_valid}, 32'd0);
    endtask

    initial begin
        int n;
        int j;
        int k;
        logic rdy;
        logic ordy;
        rst_n        = 1'b0;
        clear        = 1'b0;
        io.in_valid  = 1'b0;
        io.in_data   = 32'd0;
        io.out_ready = 1'b0;

        // reset state
        #3;
        chk("rst_in_ready",  {31'd0, io.in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, io.out_valid}, 32'd0);
        chk("rst_out_last",  {31'd0, io.out_last},  32'd0);
        chk("rst_busy",      {31'd0, busy},         32'd0);
        chk("rst_frame_cnt", {30'd0, frame_cnt},    32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("rel_in_ready",  {31'd0, io.in_ready},  32'd1);
        chk("rel_out_valid", {31'd0, io.out_valid}, 32'd0);

        // frame 1: basic function and capture latency
        io.out_ready = 1'b1;
        fa = '{30, 20, 10, 0, 0, 10, 20, 30};
        er = '{30, 21, 12, 3, 4, 15, 26, 37};
        ei = '{30, 19, 8, -3, -4, 5, 14, 23};
        for (int i = 0; i < 8; i++) feed(fa[i]);
        chk("full_in_ready", {31'd0, io.in_ready}, 32'd0);
        chk("full_busy",     {31'd0, busy},        32'd1);
        wait_valid(n);
        chk("capture_lat", 32'(n), 32'd3);
        unload(8);
        chk("f1_cnt", {30'd0, frame_cnt}, 32'd1);

        // frame 2: backpressure at bin 3
        for (int i = 0; i < 8; i++) fa[i] = 1000 + 17 * i;
        set_exp_from_fa();
        for (int i = 0; i < 8; i++) feed(fa[i]);
        wait_valid(n);
        unload(3);
        chk("f2_cnt", {30'd0, frame_cnt}, 32'd2);

        // frames 3/4: load frame 4 while frame 3 unloads
        for (int i = 0; i < 8; i++) begin
            fa[i] = 7 + 5 * i;
            fb[i] = 300 - 11 * i;
        end
        set_exp_from_fa();
        for (int i = 0; i < 8; i++) feed(fa[i]);
        wait_valid(n);
        j = 0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            io.out_ready = (c != 0);
            io.in_valid  = 1'b1;
            io.in_data   = 32'(fb[j]);
            rdy  = io.in_ready;
            ordy = io.out_ready;
            if (ordy) check_bin(k);
            tick();
            if (rdy) j++;
            if (ordy) k++;
        end
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        chk("ovl_accepted", 32'(j), 32'd8);
        chk("ovl_in_ready", {31'd0, io.in_ready}, 32'd0);
        check_bin(7);
        tick();
        chk("ovl_valid_lo", {31'd0, io.out_valid}, 32'd0);
        chk("ovl_in_ready2", {31'd0, io.in_ready}, 32'd0);
        chk("ovl_busy",     {31'd0, busy},         32'd1);
        chk("f3_cnt",       {30'd0, frame_cnt},    32'd3);
        wait_valid(n);
        chk("ovl_settle_lat", 32'(n), 32'd2);
        fa = fb;
        set_exp_from_fa();
        unload(8);
        chk("f4_cnt_wrap", {30'd0, frame_cnt}, 32'd0);

        // clear after a partial frame; same-cycle sample must be dropped
        for (int i = 0; i < 5; i++) feed(900 + i);
        chk("part_busy", {31'd0, busy}, 32'd1);
        io.in_valid = 1'b1;
        io.in_data  = 32'd999;
        clear       = 1'b1;
        tick();
        clear       = 1'b0;
        io.in_valid = 1'b0;
        chk("clr_in_ready", {31'd0, io.in_ready}, 32'd1);
        chk("clr_busy",     {31'd0, busy},        32'd0);
        chk("clr_cnt",      {30'd0, frame_cnt},   32'd0);
        for (int i = 0; i < 8; i++) fa[i] = 50 + 3 * i;
        set_exp_from_fa();
        for (int i = 0; i < 8; i++) feed(fa[i]);
        wait_valid(n);
        chk("clr_capture_lat", 32'(n), 32'd3);
        unload(8);
        chk("f5_cnt_wrap", {30'd0, frame_cnt}, 32'd1);

        // reset mid-unload at bin 4
        for (int i = 0; i < 8; i++) fa[i] = 2 + 7 * i;
        set_exp_from_fa();
        for (int i = 0; i < 8; i++) feed(fa[i]);
        wait_valid(n);
        for (int i = 0; i < 4; i++) begin
            check_bin(i);
            tick();
        end
        chk("pre_rst_idx", {29'd0, io.out_idx}, 32'd4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",    {31'd0, io.out_valid}, 32'd0);
        chk("mid_rst_cnt",      {30'd0, frame_cnt},    32'd0);
        chk("mid_rst_in_ready", {31'd0, io.in_ready},  32'd0);
        chk("mid_rst_busy",     {31'd0, busy},         32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", {31'd0, io.in_ready},  32'd1);
        chk("post_rst_valid",    {31'd0, io.out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fft8_frame_ctrl.md
Name: fft8_frame_ctrl

Overview:
- Sequencing controller for the combinational 8-point real-input FFT core (8 x 32-bit real inputs; 8 x 32-bit real and 8 x 32-bit imaginary outputs).
- Accepts a serial stream of real samples over a valid/ready handshake and assembles 8-sample frames onto the core's parallel inputs.
- Waits a programmable settle time, captures the core's 16 result words, then streams the 8 complex bins out over a second valid/ready handshake.
- Loading of frame N+1 overlaps unloading of frame N.

Parameters:
- DATA_W, 32, width of each sample and each result word.
- SETTLE, 2, cycles the core inputs are held stable before capture (1..15).
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort; discards partial input frame and any pending unload.
- in_valid  in  1  input sample valid.
- in_ready  out  1  controller can accept a sample.
- in_data  in  DATA_W  real input sample.
- core_a  out  8*DATA_W  core inputs; slice k (bits k*DATA_W +: DATA_W) drives A_k.
- core_xr  in  8*DATA_W  core real outputs; slice k = Xr_k.
- core_xi  in  8*DATA_W  core imaginary outputs; slice k = Xi_k.
- out_valid  out  1  output bin valid.
- out_ready  in  1  downstream accepts the bin.
- out_re  out  DATA_W  real part of the current bin.
- out_im  out  DATA_W  imaginary part of the current bin.
- out_idx  out  3  bin index 0..7.
- out_last  out  1  high with bin 7.
- busy  out  1  high in SETTLE, or while any result or partial frame is held.
- frame_cnt  out  CNT_W  frames fully unloaded; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst_n=0) clears all of the following; every output is 0 while in reset and immediately after:
  - core_a, result registers, wr_idx, rd_idx, settle counter, frame_cnt.
  - State machine goes to LOAD, with frame_full=0 and res_valid=0.
  - Outputs: in_ready=0 while in reset, then 1 on the first cycle after release; out_valid=0, out_last=0, busy=0.
- Input path:
  - Accept on in_valid && in_ready: write in_data to core_a slot wr_idx and increment wr_idx. Samples fill slots in arrival order, 0 first.
  - When slot 7 is written, set frame_full=1 and wrap wr_idx to 0.
  - in_ready = !frame_full && state != SETTLE.
  - core_a is held constant whenever no write occurs.
- State machine:
  - LOAD: if frame_full && !res_valid, go to SETTLE and load the settle counter with SETTLE-1. Core inputs are stable from the cycle after the last write.
  - SETTLE: decrement the counter each cycle. At 0:
    - capture core_xr/core_xi into the result registers,
    - set res_valid=1, clear frame_full, set rd_idx=0,
    - go to UNLOAD.
  - SETTLE count: capture occurs exactly SETTLE+1 cycles after the edge that wrote slot 7.
  - UNLOAD: out_valid=res_valid.
    - out_re/out_im/out_idx come from result slice rd_idx, combinationally from registers; out_last = (rd_idx==7).
    - On out_valid && out_ready: increment rd_idx.
    - On bin 7 accepted: clear res_valid, increment frame_cnt; if frame_full, go to SETTLE in the same edge, else go to LOAD.
  - Loading continues during UNLOAD. A completed next frame sets frame_full and stalls in_ready until SETTLE begins.
- Handshake rules:
  - out_re/out_im/out_idx stay stable while out_valid && !out_ready.
  - No combinational path from out_ready to in_ready, or from in_valid to out_valid.
- clear:
  - Sets wr_idx=0, rd_idx=0, frame_full=0, res_valid=0 and goes to LOAD. The settle counter is abandoned.
  - frame_cnt and core_a contents are retained.
  - clear has priority over simultaneous handshakes; a sample presented in the same cycle is dropped.
- Reset mid-operation discards all state; no partial bin is emitted.
- Throughput: with out_ready held high, 1 frame per max(8, 8+SETTLE+1) cycles in steady state.

Test Plan:
- Stub core xr_k=A_k+k, xi_k=A_k-k, SETTLE=2, out_ready=1. Stream 30,20,10,0,0,10,20,30.
  - Capture 3 cycles after the 8th accept.
  - out_re=30,21,12,3,4,15,26,37 with out_idx 0..7; out_im=30,19,8,-3,-4,5,14,23.
  - out_last only on idx 7; frame_cnt=1.
- Backpressure: hold out_ready=0 for 5 cycles at bin 3 -> bin 3 values held stable, no bin skipped or duplicated.
- Overlap: feed frame 2 continuously during the frame-1 unload.
  - in_ready drops after 8 samples of frame 2.
  - Frame 2 enters SETTLE on the edge bin 7 is accepted; frame_cnt reaches 2.
- clear asserted after 5 samples -> in_ready=1 and wr_idx=0. The next 8 samples form a fresh frame, and slot 0 gets the first post-clear sample.
- rst_n pulsed low mid-UNLOAD (bin 4) -> out_valid=0 immediately, frame_cnt=0, in_ready=1 after release.
- frame_cnt wrap with CNT_W=2: 5 frames -> reads 1.
